branch_resolve_unit: RTL and testbench

//  Execute-stage branch/jump resolver, parametrised successor to the single-cycle branch comparator.

---
 rtl/branch_resolve_unit_pkg.sv | 30 +++
 rtl/branch_resolve_unit_compare.sv | 36 +++
 rtl/branch_resolve_unit.sv | 180 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the execute-stage branch resolver: control-flow kinds and
// branch conditions (funct3), plus the status flags carried in the result register.
package branch_resolve_unit_pkg;

   typedef enum logic [1:0] {
      CF_NONE   = 2'd0,
      CF_BRANCH = 2'd1,
      CF_JAL    = 2'd2,
      CF_JALR   = 2'd3
   } cf_kind_e;

   localparam logic [2:0] BRANCH_BEQ  = 3'b000;
   localparam logic [2:0] BRANCH_BNE  = 3'b001;
   localparam logic [2:0] BRANCH_BLT  = 3'b100;
   localparam logic [2:0] BRANCH_BGE  = 3'b101;
   localparam logic [2:0] BRANCH_BLTU = 3'b110;
   localparam logic [2:0] BRANCH_BGEU = 3'b111;

   typedef struct packed {
      logic taken;
      logic mispredict;
      logic misalign;
      logic is_cf;
   } res_flags_t;

   function automatic logic is_cf_kind(input logic [1:0] kind);
      return (kind != CF_NONE);
   endfunction

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// Combinational branch condition evaluator: decodes funct3 and compares two operands.
// Undefined condition encodings resolve to not-taken.
module branch_compare
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            taken_o
);

   logic eq_s;
   logic lt_s;
   logic ltu_s;

   assign eq_s  = (a_i == b_i);
   assign lt_s  = ($signed(a_i) < $signed(b_i));
   assign ltu_s = (a_i < b_i);

   // condition decode
   always_comb begin
      taken_o = 1'b0;
      case (op_i)
         BRANCH_BEQ:  taken_o = eq_s;
         BRANCH_BNE:  taken_o = !eq_s;
         BRANCH_BLT:  taken_o = lt_s;
         BRANCH_BGE:  taken_o = !lt_s;
         BRANCH_BLTU: taken_o = ltu_s;
         BRANCH_BGEU: taken_o = !ltu_s;
         default:     taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: resolves direction/target/link, checks against the
// fetch prediction, registers a redirect result and keeps saturating perf counters.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32,
   parameter int unsigned ALIGN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_kind,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             in_pred_taken,
   input  logic [XLEN-1:0]  in_pred_target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_target,
   output logic [XLEN-1:0]  out_link,
   output logic             out_mispredict,
   output logic [XLEN-1:0]  out_redirect_pc,
   output logic             out_misalign,
   output logic [CNT_W-1:0] perf_cf_cnt,
   output logic [CNT_W-1:0] perf_mispred_cnt
);

   localparam logic [XLEN-1:0]  ALIGN_MASK = XLEN'(ALIGN - 1);
   localparam logic [XLEN-1:0]  JALR_MASK  = ~XLEN'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   logic            cmp_taken_s;
   logic            taken_s;
   logic [XLEN-1:0] pc_imm_s;
   logic [XLEN-1:0] rs1_imm_s;
   logic [XLEN-1:0] link_s;
   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] redirect_s;
   res_flags_t      flags_s;
   logic            accept_s;
   logic            fire_s;

   logic             out_valid_d;
   logic [CNT_W-1:0] cf_cnt_d;
   logic [CNT_W-1:0] mp_cnt_d;

   logic             out_valid_q;
   res_flags_t       flags_q;
   logic [XLEN-1:0]  target_q;
   logic [XLEN-1:0]  link_q;
   logic [XLEN-1:0]  redirect_q;
   logic [CNT_W-1:0] cf_cnt_q;
   logic [CNT_W-1:0] mp_cnt_q;

   branch_compare #(
      .XLEN (XLEN)
   ) u_compare (
      .op_i    (in_op),
      .a_i     (in_rs1),
      .b_i     (in_rs2),
      .taken_o (cmp_taken_s)
   );

   assign pc_imm_s  = in_pc + in_imm;
   assign rs1_imm_s = in_rs1 + in_imm;
   assign link_s    = in_pc + XLEN'(4);

   // direction and target per control-flow kind
   always_comb begin
      taken_s  = 1'b0;
      target_s = link_s;
      case (in_kind)
         CF_BRANCH: begin
            taken_s  = cmp_taken_s;
            target_s = pc_imm_s;
         end
         CF_JAL: begin
            taken_s  = 1'b1;
            target_s = pc_imm_s;
         end
         CF_JALR: begin
            taken_s  = 1'b1;
            target_s = rs1_imm_s & JALR_MASK;
         end
         CF_NONE: begin
            taken_s  = 1'b0;
            target_s = link_s;
         end
         default: begin
            taken_s  = 1'b0;
            target_s = link_s;
         end
      endcase
   end

   // A not-taken op predicted not-taken never mispredicts, whatever the predicted target.
   always_comb begin
      flags_s.taken      = taken_s;
      flags_s.mispredict = (taken_s != in_pred_taken) ||
                           (taken_s && (target_s != in_pred_target));
      flags_s.misalign   = taken_s && ((target_s & ALIGN_MASK) != {XLEN{1'b0}});
      flags_s.is_cf      = is_cf_kind(in_kind);
      redirect_s         = taken_s ? target_s : link_s;
   end

   assign in_ready = !out_valid_q || out_ready;
   assign accept_s = in_valid && in_ready && !flush;
   assign fire_s   = out_valid_q && out_ready;

   // output-valid next state
   always_comb begin
      if (accept_s) begin
         out_valid_d = 1'b1;
      end else if (out_ready || flush) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // saturating counter next state, advanced only when a result leaves
   always_comb begin
      if (fire_s && flags_q.is_cf && (cf_cnt_q != CNT_MAX)) begin
         cf_cnt_d = cf_cnt_q + CNT_W'(1);
      end else begin
         cf_cnt_d = cf_cnt_q;
      end
      if (fire_s && flags_q.mispredict && (mp_cnt_q != CNT_MAX)) begin
         mp_cnt_d = mp_cnt_q + CNT_W'(1);
      end else begin
         mp_cnt_d = mp_cnt_q;
      end
   end

   // result register and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         flags_q     <= '0;
         target_q    <= {XLEN{1'b0}};
         link_q      <= {XLEN{1'b0}};
         redirect_q  <= {XLEN{1'b0}};
         cf_cnt_q    <= {CNT_W{1'b0}};
         mp_cnt_q    <= {CNT_W{1'b0}};
      end else begin
         out_valid_q <= out_valid_d;
         cf_cnt_q    <= cf_cnt_d;
         mp_cnt_q    <= mp_cnt_d;
         if (accept_s) begin
            flags_q    <= flags_s;
            target_q   <= target_s;
            link_q     <= link_s;
            redirect_q <= redirect_s;
         end else begin
            flags_q    <= flags_q;
            target_q   <= target_q;
            link_q     <= link_q;
            redirect_q <= redirect_q;
         end
      end
   end

   assign out_valid        = out_valid_q;
   assign out_taken        = flags_q.taken;
   assign out_target       = target_q;
   assign out_link         = link_q;
   assign out_mispredict   = flags_q.mispredict;
   assign out_redirect_pc  = redirect_q;
   assign out_misalign     = flags_q.misalign;
   assign perf_cf_cnt      = cf_cnt_q;
   assign perf_mispred_cnt = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table, hand-written
// handshake/flush/reset/saturation sequences, then random traffic against a reference model.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  in_kind = 2'd0;
   logic [2:0]  in_op = 3'd0;
   logic [31:0] in_pc = 32'd0, in_rs1 = 32'd0, in_rs2 = 32'd0, in_imm = 32'd0;
   logic        in_pred_taken = 1'b0;
   logic [31:0] in_pred_target = 32'd0;

   logic        in_ready, out_valid, out_taken, out_mispredict, out_misalign;
   logic [31:0] out_target, out_link, out_redirect_pc, perf_cf_cnt, perf_mispred_cnt;
   logic        in_ready4, out_valid4, out_taken4, out_mispredict4, out_misalign4;
   logic [31:0] out_target4, out_link4, out_redirect_pc4;
   logic [3:0]  perf_cf_cnt4, perf_mispred_cnt4;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(32), .CNT_W(32), .ALIGN(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_op(in_op), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_imm(in_imm), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_target(out_target), .out_link(out_link), .out_mispredict(out_mispredict),
      .out_redirect_pc(out_redirect_pc), .out_misalign(out_misalign),
      .perf_cf_cnt(perf_cf_cnt), .perf_mispred_cnt(perf_mispred_cnt));

   branch_resolve_unit #(.XLEN(32), .CNT_W(4), .ALIGN(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
      .in_kind(in_kind), .in_op(in_op), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_imm(in_imm), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .out_valid(out_valid4), .out_ready(out_ready), .out_taken(out_taken4),
      .out_target(out_target4), .out_link(out_link4), .out_mispredict(out_mispredict4),
      .out_redirect_pc(out_redirect_pc4), .out_misalign(out_misalign4),
      .perf_cf_cnt(perf_cf_cnt4), .perf_mispred_cnt(perf_mispred_cnt4));

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] link;
      logic        mis;
      logic [31:0] redir;
      logic        misal;
      logic        is_cf;
   } res_t;

   typedef struct {
      logic [1:0]  kind;
      logic [2:0]  op;
      logic [31:0] pc, rs1, rs2, imm;
      logic        pt;
      logic [31:0] ptgt;
      logic        e_taken;
      logic [31:0] e_target;
      logic        e_mis;
      logic [31:0] e_redir;
      logic        e_misal;
   } vec_t;

   // model state
   logic       m_valid = 1'b0;
   res_t       m_res = '0;
   logic [31:0] m_cf = 32'd0, m_mp = 32'd0;
   logic [3:0]  m_cf4 = 4'd0, m_mp4 = 4'd0;

   // Resolution from the ISA rules, using wide integer arithmetic.
   function automatic res_t ref_model(input logic [1:0] k, input logic [2:0] op,
                                      input logic [31:0] pc, rs1, rs2, imm,
                                      input logic pt, input logic [31:0] ptgt);
      res_t r;
      longint sa, sb, ua, ub;
      longint unsigned s;
      sa = longint'($signed(rs1));
      sb = longint'($signed(rs2));
      ua = longint'({32'd0, rs1});
      ub = longint'({32'd0, rs2});
      r.link   = 32'((longint'({32'd0, pc}) + 64'd4) % 64'h1_0000_0000);
      r.taken  = 1'b0;
      r.target = r.link;
      if (k == 2'd1) begin
         case (op)
            3'b000:  r.taken = (ua == ub);
            3'b001:  r.taken = (ua != ub);
            3'b100:  r.taken = (sa < sb);
            3'b101:  r.taken = (sa >= sb);
            3'b110:  r.taken = (ua < ub);
            3'b111:  r.taken = (ua >= ub);
            default: r.taken = 1'b0;
         endcase
         r.target = 32'(({32'd0, pc} + {32'd0, imm}) % 64'h1_0000_0000);
      end else if (k == 2'd2) begin
         r.taken  = 1'b1;
         r.target = 32'(({32'd0, pc} + {32'd0, imm}) % 64'h1_0000_0000);
      end else if (k == 2'd3) begin
         r.taken  = 1'b1;
         s = ({32'd0, rs1} + {32'd0, imm}) % 64'h1_0000_0000;
         r.target = 32'(s - (s % 64'd2));
      end
      r.is_cf = (k != 2'd0);
      r.mis   = (r.taken != pt) || (r.taken && (r.target != ptgt));
      r.redir = r.taken ? r.target : r.link;
      r.misal = r.taken && ((r.target % 32'd4) != 32'd0);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_valid4", 64'(out_valid4), 64'(m_valid));
      chk("perf_cf", 64'(perf_cf_cnt), 64'(m_cf));
      chk("perf_mp", 64'(perf_mispred_cnt), 64'(m_mp));
      chk("perf_cf4", 64'(perf_cf_cnt4), 64'(m_cf4));
      chk("perf_mp4", 64'(perf_mispred_cnt4), 64'(m_mp4));
      if (m_valid) begin
         chk("taken", 64'(out_taken), 64'(m_res.taken));
         chk("target", 64'(out_target), 64'(m_res.target));
         chk("link", 64'(out_link), 64'(m_res.link));
         chk("mispredict", 64'(out_mispredict), 64'(m_res.mis));
         chk("redirect", 64'(out_redirect_pc), 64'(m_res.redir));
         chk("misalign", 64'(out_misalign), 64'(m_res.misal));
         chk("redirect4", 64'(out_redirect_pc4), 64'(m_res.redir));
         chk("misalign4", 64'(out_misalign4 ^ out_taken4 ^ out_mispredict4), 64'(m_res.misal ^ m_res.taken ^ m_res.mis));
         chk("tgt_link4", 64'({out_target4, out_link4}), {m_res.target, m_res.link});
      end
   endtask

   // One clock with the currently driven inputs; the model advances by the handshake rules.
   task automatic tick();
      logic rdy, fire, acc;
      #1;
      rdy = !m_valid || out_ready;
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("in_ready4", 64'(in_ready4), 64'(rdy));
      fire = m_valid && out_ready;
      acc  = in_valid && rdy && !flush;
      @(posedge clk);
      #1;
      if (fire) begin
         if (m_res.is_cf && m_cf != 32'hFFFF_FFFF) m_cf = m_cf + 32'd1;
         if (m_res.mis && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 32'd1;
         if (m_res.is_cf && m_cf4 != 4'hF) m_cf4 = m_cf4 + 4'd1;
         if (m_res.mis && m_mp4 != 4'hF) m_mp4 = m_mp4 + 4'd1;
      end
      if (acc) begin
         m_res = ref_model(in_kind, in_op, in_pc, in_rs1, in_rs2, in_imm, in_pred_taken, in_pred_target);
         m_valid = 1'b1;
      end else if (out_ready || flush) begin
         m_valid = 1'b0;
      end
      check_outputs();
   endtask

   task automatic set_op(input logic [1:0] k, input logic [2:0] op, input logic [31:0] pc,
                         input logic [31:0] rs1, rs2, imm, input logic pt, input logic [31:0] ptgt);
      in_kind = k; in_op = op; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_pred_taken = pt; in_pred_target = ptgt;
   endtask

   function automatic vec_t mk(input logic [1:0] k, input logic [2:0] op, input logic [31:0] pc,
                               input logic [31:0] rs1, rs2, imm, input logic pt,
                               input logic [31:0] ptgt, input logic et, input logic [31:0] etg,
                               input logic em, input logic [31:0] er, input logic ea);
      vec_t v;
      v.kind = k; v.op = op; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
      v.pt = pt; v.ptgt = ptgt; v.e_taken = et; v.e_target = etg; v.e_mis = em;
      v.e_redir = er; v.e_misal = ea;
      return v;
   endfunction

   vec_t vt[13];
   res_t tmp;
   logic [31:0] cf_base;

   initial begin
      vt[0]  = mk(2'd1, 3'b100, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0, 1'b1, 32'h120, 1'b1, 32'h120, 1'b0);
      vt[1]  = mk(2'd1, 3'b110, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0, 1'b0, 32'h120, 1'b0, 32'h104, 1'b0);
      vt[2]  = mk(2'd3, 3'b000, 32'h200, 32'h1001, 32'd0, 32'h4, 1'b1, 32'h1004, 1'b1, 32'h1004, 1'b0, 32'h1004, 1'b0);
      vt[3]  = mk(2'd3, 3'b000, 32'h200, 32'h1003, 32'd0, 32'h4, 1'b1, 32'h1004, 1'b1, 32'h1006, 1'b1, 32'h1006, 1'b1);
      vt[4]  = mk(2'd2, 3'b000, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 32'h10, 1'b0);
      vt[5]  = mk(2'd1, 3'b000, 32'h300, 32'd5, 32'd5, 32'hFFFF_FFF0, 1'b1, 32'h2F0, 1'b1, 32'h2F0, 1'b0, 32'h2F0, 1'b0);
      vt[6]  = mk(2'd1, 3'b001, 32'h300, 32'd5, 32'd5, 32'hFFFF_FFF0, 1'b1, 32'h2F0, 1'b0, 32'h2F0, 1'b1, 32'h304, 1'b0);
      vt[7]  = mk(2'd1, 3'b101, 32'h300, 32'h8000_0000, 32'd0, 32'hFFFF_FFF0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h2F0, 1'b0, 32'h304, 1'b0);
      vt[8]  = mk(2'd1, 3'b111, 32'h400, 32'h8000_0000, 32'd0, 32'h6, 1'b1, 32'h406, 1'b1, 32'h406, 1'b0, 32'h406, 1'b1);
      vt[9]  = mk(2'd1, 3'b010, 32'h500, 32'd1, 32'd2, 32'h8, 1'b1, 32'h508, 1'b0, 32'h508, 1'b1, 32'h504, 1'b0);
      vt[10] = mk(2'd0, 3'b000, 32'h600, 32'd1, 32'd1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h604, 1'b0, 32'h604, 1'b0);
      vt[11] = mk(2'd2, 3'b000, 32'h700, 32'd0, 32'd0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h800, 1'b1, 32'h800, 1'b0);
      vt[12] = mk(2'd1, 3'b100, 32'h800, 32'd1, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0, 1'b0, 32'h810, 1'b0, 32'h804, 1'b0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      chk("rst_taken", 64'(out_taken), 64'd0);
      chk("rst_target", 64'(out_target), 64'd0);
      chk("rst_redirect", 64'(out_redirect_pc), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;

      // directed vectors, full throughput
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         set_op(vt[i].kind, vt[i].op, vt[i].pc, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].pt, vt[i].ptgt);
         in_valid = 1'b1;
         tick();
         chk($sformatf("vec%0d_taken", i), 64'(out_taken), 64'(vt[i].e_taken));
         chk($sformatf("vec%0d_target", i), 64'(out_target), 64'(vt[i].e_target));
         chk($sformatf("vec%0d_mis", i), 64'(out_mispredict), 64'(vt[i].e_mis));
         chk($sformatf("vec%0d_redir", i), 64'(out_redirect_pc), 64'(vt[i].e_redir));
         chk($sformatf("vec%0d_misal", i), 64'(out_misalign), 64'(vt[i].e_misal));
         chk($sformatf("vec%0d_link", i), 64'(out_link), 64'(vt[i].pc + 32'd4));
      end
      in_valid = 1'b0;
      tick();

      // backpressure: hold for 3 cycles, then drain and accept back-to-back
      out_ready = 1'b0;
      set_op(2'd2, 3'b000, 32'h1000, 32'd0, 32'd0, 32'h40, 1'b1, 32'h1040);
      in_valid = 1'b1;
      tick();
      cf_base = m_cf;
      set_op(2'd1, 3'b000, 32'h2000, 32'd7, 32'd7, 32'h8, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_target", 64'(out_target), 64'h1040);
         chk("bp_cf_cnt", 64'(perf_cf_cnt), 64'(cf_base));
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release_cnt", 64'(perf_cf_cnt), 64'(cf_base + 32'd1));
      chk("bp_b2b_valid", 64'(out_valid), 64'd1);
      chk("bp_b2b_target", 64'(out_target), 64'h2008);
      in_valid = 1'b0;
      tick();

      // flush while holding, with downstream handshake in the same cycle
      out_ready = 1'b0;
      set_op(2'd3, 3'b000, 32'h3000, 32'h500, 32'd0, 32'h0, 1'b0, 32'h0);
      in_valid = 1'b1;
      tick();
      cf_base = m_cf;
      set_op(2'd2, 3'b000, 32'h4000, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0);
      flush = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_cnt", 64'(perf_cf_cnt), 64'(cf_base + 32'd1));
      flush = 1'b0;
      in_valid = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // asynchronous reset mid-stream while holding a result
      out_ready = 1'b0;
      set_op(2'd2, 3'b000, 32'h5000, 32'd0, 32'd0, 32'h14, 1'b0, 32'h0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      m_valid = 1'b0; m_cf = 32'd0; m_mp = 32'd0; m_cf4 = 4'd0; m_mp4 = 4'd0;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_target", 64'(out_target), 64'd0);
      chk("arst_link", 64'(out_link), 64'd0);
      chk("arst_flags", 64'({out_taken, out_mispredict, out_misalign}), 64'd0);
      chk("arst_cf", 64'(perf_cf_cnt), 64'd0);
      chk("arst_mp4", 64'(perf_mispred_cnt4), 64'd0);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      set_op(2'd2, 3'b000, 32'h6000, 32'd0, 32'd0, 32'h10, 1'b1, 32'h6010);
      in_valid = 1'b1;
      tick();
      chk("post_rst_target", 64'(out_target), 64'h6010);
      chk("post_rst_mis", 64'(out_mispredict), 64'd0);

      // counter saturation: 16 mispredicts into a 4-bit counter
      set_op(2'd2, 3'b000, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 1'b0, 32'h0);
      for (int i = 0; i < 16; i++) tick();
      in_valid = 1'b0;
      tick();
      chk("sat_mp4", 64'(perf_mispred_cnt4), 64'hF);
      chk("sat_cf4", 64'(perf_cf_cnt4), 64'hF);
      chk("sat_mp32", 64'(perf_mispred_cnt), 64'd16);
      chk("sat_cf32", 64'(perf_cf_cnt), 64'd17);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 9) == 0);
         in_kind   = 2'($urandom_range(0, 3));
         in_op     = 3'($urandom_range(0, 7));
         in_pc     = $urandom;
         in_rs1    = $urandom;
         in_rs2    = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom;
         in_imm    = ($urandom_range(0, 1) == 0) ? $urandom : (32'($urandom_range(0, 64)) - 32'd32);
         in_pred_taken = 1'($urandom_range(0, 1));
         tmp = ref_model(in_kind, in_op, in_pc, in_rs1, in_rs2, in_imm, in_pred_taken, 32'd0);
         in_pred_target = ($urandom_range(0, 1) == 0) ? tmp.target : $urandom;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
